// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the riscv_single_cycle core.
// Contents:
//   - RV32I opcode constants for the supported subset
//   - ALU operation, immediate format and writeback select enums
//   - decoded control bundle (ctrl_t)
//   - imm_gen(): sign-extended immediate builder for I/S/B/J formats
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd5
    } alusel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3
    } immsel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbsel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    alu_src_imm;
        logic    branch;
        logic    jump;
        immsel_e imm_sel;
        alusel_e alu_sel;
        wbsel_e  wb_sel;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input immsel_e sel);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/riscv_single_cycle_regfile.sv
// riscv_regfile: 32-entry register file with x0 hardwired to zero.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high clear of every register
//   rs1, rs2   combinational read addresses
//   rd1, rd2   read data
//   we         write enable (ignored when rd == 0)
//   rd, wd     write address / write data, written at the rising edge
module riscv_regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  we,
    input  logic [4:0]            rd,
    input  logic [DATA_WIDTH-1:0] wd
);

    logic [DATA_WIDTH-1:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd != 5'd0)) begin
            regs[rd] <= wd;
        end
    end

    assign rd1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];

endmodule

// File: rtl/riscv_single_cycle.sv
// riscv_single_cycle: single-cycle RV32I-subset core (add/sub/and/or/slt,
// addi/andi/ori/slti, lw/sw, beq, jal). One instruction retires per rising
// clock edge. IMEM (256 words, combinational, indexed by pc[9:2]) is preloaded
// externally; DMEM (1024 words) is indexed directly by alu_result[9:0]
// without a word shift.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, asserted HIGH despite its name: clears PC,
//            register file and DMEM
// Optional: define RISCV_TRACE_EN to print a per-instruction retire trace.
module riscv_single_cycle #(
  parameter int    INST_WIDTH         = 32,
  parameter int    IMMSEL_WIDTH       = 3,
  parameter int    PC_WIDTH           = 32,
  parameter int    DATA_WIDTH         = 32,
  parameter int    DATAMEM_ADDR_WIDTH = 32,
  parameter int    ALUSEL_WIDTH       = 3,
  parameter string IMEM_FILE          = "program.hex"
) (
  input logic clk,
  input logic reset_n
);
  import riscv_pkg::*;

  logic [PC_WIDTH-1:0]           pc;
  logic [PC_WIDTH-1:0]           pc_plus4;
  logic [PC_WIDTH-1:0]           pc_next;
  logic [INST_WIDTH-1:0]         inst;
  logic [INST_WIDTH-1:0]         imem [0:255];
  logic [DATA_WIDTH-1:0]         dmem [0:1023];
  ctrl_t                         ctrl;
  logic [DATA_WIDTH-1:0]         imm;
  logic [DATA_WIDTH-1:0]         rd1;
  logic [DATA_WIDTH-1:0]         rd2;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [DATAMEM_ADDR_WIDTH-1:0] alu_result;
  logic                          zero;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic [DATA_WIDTH-1:0]         wb_data;
  logic                          take_target;

  // ---------------- fetch ----------------
  assign inst     = imem[pc[9:2]];
  assign pc_plus4 = pc + PC_WIDTH'(4);

  // ---------------- decode ----------------
  always_comb begin
    ctrl         = '0;
    ctrl.imm_sel = IMM_I;
    ctrl.alu_sel = ALU_ADD;
    ctrl.wb_sel  = WB_ALU;
    case (inst[6:0])
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case (inst[14:12])
          3'b000:  ctrl.alu_sel = inst[30] ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl.alu_sel = ALU_AND;
          3'b110:  ctrl.alu_sel = ALU_OR;
          3'b010:  ctrl.alu_sel = ALU_SLT;
          default: ctrl.alu_sel = ALU_ADD;
        endcase
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        case (inst[14:12])
          3'b111:  ctrl.alu_sel = ALU_AND;
          3'b110:  ctrl.alu_sel = ALU_OR;
          3'b010:  ctrl.alu_sel = ALU_SLT;
          default: ctrl.alu_sel = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.wb_sel      = WB_MEM;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.imm_sel     = IMM_S;
      end
      OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_sel = IMM_B;
        ctrl.alu_sel = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.wb_sel    = WB_PC4;
      end
      default: ;
    endcase
  end

  assign imm = DATA_WIDTH'(imm_gen(32'(inst), ctrl.imm_sel));

  riscv_regfile #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .reset (reset_n),
    .rs1   (inst[19:15]),
    .rs2   (inst[24:20]),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (ctrl.reg_write),
    .rd    (inst[11:7]),
    .wd    (wb_data)
  );

  // ---------------- execute ----------------
  assign alu_b = ctrl.alu_src_imm ? imm : rd2;

  always_comb begin
    alu_result = '0;
    case (ctrl.alu_sel)
      ALU_ADD: alu_result = DATAMEM_ADDR_WIDTH'(rd1 + alu_b);
      ALU_SUB: alu_result = DATAMEM_ADDR_WIDTH'(rd1 - alu_b);
      ALU_AND: alu_result = DATAMEM_ADDR_WIDTH'(rd1 & alu_b);
      ALU_OR:  alu_result = DATAMEM_ADDR_WIDTH'(rd1 | alu_b);
      ALU_SLT: alu_result = DATAMEM_ADDR_WIDTH'($signed(rd1) < $signed(alu_b));
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // ---------------- memory / writeback ----------------
  assign mem_rdata = dmem[alu_result[9:0]];

  always_comb begin
    wb_data = '0;
    case (ctrl.wb_sel)
      WB_ALU:  wb_data = DATA_WIDTH'(alu_result);
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = DATA_WIDTH'(pc_plus4);
      default: wb_data = '0;
    endcase
  end

  // ---------------- next PC ----------------
  assign take_target = ctrl.jump | (ctrl.branch & zero);
  assign pc_next     = take_target ? (pc + PC_WIDTH'(imm)) : pc_plus4;

  // Reset takes priority so an instruction in flight at reset writes nothing.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc <= '0;
      for (int unsigned i = 0; i < 1024; i++) begin
        dmem[i] <= '0;
      end
    end else begin
      pc <= pc_next;
      if (ctrl.mem_write) begin
        dmem[alu_result[9:0]] <= rd2;
      end
    end
  end

`ifdef RISCV_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if (ctrl.reg_write && inst[11:7] != 5'd0)
        $display("%0t pc=%08h inst=%08h x%0d<=%08h", $time, pc, inst, inst[11:7], wb_data);
      else if (ctrl.mem_write)
        $display("%0t pc=%08h inst=%08h mem[%0d]<=%08h", $time, pc, inst, alu_result[9:0], rd2);
      else
        $display("%0t pc=%08h inst=%08h", $time, pc, inst);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_single_cycle.sv
// tb_riscv_single_cycle: directed self-checking bench for riscv_single_cycle.
// Loads the 21-instruction reference program into IMEM, then checks PC,
// registers and DMEM after each retiring edge, across a full run, a reset
// after completion, a reset in the middle of the program and a re-run.
module tb_riscv_single_cycle;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    riscv_single_cycle #(
        .IMEM_FILE("")
    ) dut (
        .clk     (clk),
        .reset_n (reset_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] prog [0:20] = '{
        32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233,
        32'h0041F2B3, 32'h004282B3, 32'h02728863, 32'h0041A233,
        32'h00020463, 32'h00000293, 32'h0023A233, 32'h005203B3,
        32'h402383B3, 32'h0471AA23, 32'h06002103, 32'h005104B3,
        32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
        32'h00210063
    };

    // Expected state after edge e (1-based): PC, and one register of interest.
    logic [31:0] exp_pc  [1:20] = '{
        32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
        32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h48,
        32'h4C, 32'h50, 32'h50, 32'h50
    };
    int          exp_reg [1:20] = '{2, 3, 7, 4, 5, 5, 5, 4, 4, 4, 7, 7, 7, 2, 9, 3, 2, 2, 2, 9};
    logic [31:0] exp_val [1:20] = '{
        32'd5, 32'd12, 32'd3, 32'd7, 32'd4, 32'd11, 32'd11, 32'd0,
        32'd0, 32'd1, 32'd12, 32'd7, 32'd7, 32'd7, 32'd18, 32'h44,
        32'd25, 32'd25, 32'd25, 32'd18
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check($sformatf("%s pc", tag), dut.pc, 32'h0);
        for (int r = 1; r < 10; r++)
            check($sformatf("%s x%0d", tag, r), dut.u_regfile.regs[r], 32'h0);
        check($sformatf("%s dmem96", tag), dut.dmem[96], 32'h0);
        check($sformatf("%s dmem100", tag), dut.dmem[100], 32'h0);
    endtask

    task automatic run_edges(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            step();
            check($sformatf("%s e%0d pc", tag, e), dut.pc, exp_pc[e]);
            check($sformatf("%s e%0d x%0d", tag, e, exp_reg[e]),
                  dut.u_regfile.regs[exp_reg[e]], exp_val[e]);
            if (e == 13) check($sformatf("%s e13 dmem96", tag), dut.dmem[96], 32'd7);
            if (e == 18) begin
                check($sformatf("%s e18 dmem100", tag), dut.dmem[100], 32'd25);
                check($sformatf("%s e18 x3", tag), dut.u_regfile.regs[3], 32'h44);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
        for (int i = 0; i < 21; i++) dut.imem[i] = prog[i];

        // Power-on reset for one edge.
        reset_n = 1'b1;
        step();
        check_cleared("por");
        check("por x0", dut.u_regfile.regs[0], 32'h0);
        reset_n = 1'b0;

        // Full program, then hold on the final self-loop.
        run_edges("run1", 20);
        check("run1 x0", dut.u_regfile.regs[0], 32'h0);

        // Reset after completion clears regs and DMEM that were non-zero.
        reset_n = 1'b1;
        step();
        check_cleared("rst_end");
        reset_n = 1'b0;

        // Reset asserted for edge 10: the slt at 0x28 must not write x4.
        run_edges("run2", 9);
        reset_n = 1'b1;
        step();
        check_cleared("rst_mid");
        reset_n = 1'b0;

        // Re-run reproduces the same sequence.
        run_edges("run3", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/riscv_single_cycle.md
Name: riscv_single_cycle

Overview:
Single-cycle RV32I-subset processor with instruction memory (IMEM), data memory (DMEM), register file, ALU, immediate generator and main/ALU decoder. Every rising clk edge fetches, executes and retires one instruction, updating PC, register file and DMEM. The block is the top-level core; it has no bus ports and only clock and reset enter it.

Parameters:
INST_WIDTH, 32, instruction width
IMMSEL_WIDTH, 3, immediate-format select width (I/S/B/J)
PC_WIDTH, 32, program counter width
DATA_WIDTH, 32, register and data word width
DATAMEM_ADDR_WIDTH, 32, DMEM address width (ALU result)
ALUSEL_WIDTH, 3, ALU operation select width
IMEM_FILE, "program.hex", $readmemh image for IMEM (one 32-bit word per line, word 0 at address 0)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  synchronous active-high reset: reset is asserted when reset_n=1 and sampled at the rising clk edge

Behaviour:
- Reset (reset_n=1 at a rising edge): PC<=0; all 32 registers <=0; all DMEM words <=0. IMEM is not cleared.
- Reset mid-program: the next edge with reset asserted forces PC=0 and clears the register file and DMEM. No write from the current instruction takes effect.
- IMEM: 256 x 32-bit words, combinational read, indexed by PC[9:2].
- Register file: 32 x DATA_WIDTH, two combinational read ports, one write port written at the rising edge. x0 always reads 0; writes to x0 are discarded.
- DMEM: 1024 x DATA_WIDTH words, indexed directly by ALU result [9:0] with no shift (byte address 96 -> entry 96). Read is combinational. sw writes at the rising edge.
- Supported instructions:
  - R-type: add, sub, and, or, slt (signed).
  - I-type: addi, andi, ori, slti.
  - Loads/stores: lw, sw.
  - Branch: beq.
  - Jump: jal (rd<=PC+4).
- Next-PC: PC+4 by default; PC+immB when beq is taken; PC+immJ for jal.
- Unrecognised opcode: executes as NOP (no register or DMEM write, PC+4).
- Immediates are sign-extended:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- ALU ops (ALUSEL codes): ADD=0, SUB=1, AND=2, OR=3, SLT=5. The ALU produces a zero flag that drives beq. Arithmetic wraps modulo 2^32.
- Writeback mux selects ALU result, DMEM read data, or PC+4.
- Latency: one instruction per cycle. Register and DMEM results are visible immediately after the edge that executes the instruction.

Optional Feature:
RISCV_TRACE_EN — when defined, each retiring instruction $displays time, PC, instruction word, rd/value written (if any) and DMEM address/data stored (if any). When undefined, there is no display logic; behaviour is identical otherwise.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP_R=0110011, OP_I=0010011, OP_LW=0000011, OP_SW=0100011, OP_BEQ=1100011, OP_JAL=1101111);
  - ALUSEL and IMMSEL enums;
  - writeback-select enum.
- Sub-module riscv_regfile (32x32, x0 hardwired) is the natural split. ALU, decoder, IMEM and DMEM stay in the top.

Test Plan:
Every scenario loads the standard 21-instruction program below, asserts reset for one edge, then checks state after each following rising edge:
0x00 addi x2,x0,5; 0x04 addi x3,x0,12; 0x08 addi x7,x3,-9; 0x0C or x4,x7,x2; 0x10 and x5,x3,x4; 0x14 add x5,x5,x4; 0x18 beq x5,x7,+48; 0x1C slt x4,x3,x4; 0x20 beq x4,x0,+8; 0x24 addi x5,x0,0; 0x28 slt x4,x7,x2; 0x2C add x7,x4,x5; 0x30 sub x7,x7,x2; 0x34 sw x7,84(x3); 0x38 lw x2,96(x0); 0x3C add x9,x2,x5; 0x40 jal x3,+8; 0x44 addi x2,x0,1; 0x48 add x2,x2,x9; 0x4C sw x2,0x20(x3); 0x50 beq x2,x2,0.
- ALU sequence: after edges 1-6, x2=5, x3=12, x7=3, x4=7, x5=4, x5=11.
- Branches: edge 7 (beq not taken) -> PC=0x1C; edge 8 -> x4=0; edge 9 (beq taken) -> PC=0x28, skipping 0x24.
- slt/sub: edges 10-12 -> x4=1, x7=12, x7=7.
- Memory: edge 13 -> DMEM[96]=7; edge 14 (lw) -> x2=7; edge 15 -> x9=18.
- Jump: edge 16 (jal) -> PC=0x48, x3=0x44; edge 17 -> x2=25; edge 18 -> DMEM[100]=25; further edges hold PC=0x50.
- Reset mid-run: assert reset at edge 10 -> PC=0, x2..x9=0, DMEM[96]=0. Deassert, re-run -> same sequence reproduced.
